// File: rtl/right_map_index_fetch_if.sv
// Scan-position, map-ROM and room-slide signals shared between the index fetch stage
// and its surroundings (scan generator, map ROM, room controller, palette stage).
interface right_map_index_fetch_if #(
    parameter int ADDR_W = 18
);
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank_n;
    logic              frame_start;
    logic              room_req;
    logic              room_dir;
    logic              room_ack;
    logic [ADDR_W-1:0] rom_addr;
    logic [4:0]        rom_q;
    logic [4:0]        idx_out;
    logic              idx_valid;
    logic              sliding;
    logic              slide_done;

    // The fetch stage itself.
    modport slave (
        input  DrawX, DrawY, blank_n, frame_start, room_req, room_dir, rom_q,
        output room_ack, rom_addr, idx_out, idx_valid, sliding, slide_done
    );

    // Everything around it: scan timing, ROM, room controller, palette consumer.
    modport master (
        output DrawX, DrawY, blank_n, frame_start, room_req, room_dir, rom_q,
        input  room_ack, rom_addr, idx_out, idx_valid, sliding, slide_done
    );
endinterface

// File: rtl/right_map_index_fetch.sv
// Turns the scan position into a map ROM address, returns the blank-masked colour index
// four cycles later, and owns the horizontal room-slide offset.
module right_map_index_fetch #(
    parameter int MAP_W    = 320,
    parameter int MAP_H    = 240,
    parameter int WORLD_W  = 640,
    parameter int SCALE_SH = 1,
    parameter int ROM_LAT  = 2,
    parameter int STEP     = 8,
    parameter int BG_IDX   = 15,
    parameter int ADDR_W   = 18
) (
    input  logic                  Clk,
    input  logic                  Reset,
    right_map_index_fetch_if.slave bus
);

    localparam int XW = $clog2(MAP_W + 1);

    if (WORLD_W != 2 * MAP_W || ADDR_W < $clog2(WORLD_W * MAP_H) || ROM_LAT < 1) begin : g_bad_params
        $error("right_map_index_fetch: inconsistent geometry parameters");
    end

    typedef enum logic [1:0] {
        IDLE,
        SLIDE_R,
        SLIDE_L,
        DONE
    } state_t;

    state_t            state;
    logic [XW-1:0]     x_off;
    logic [XW-1:0]     x_right;
    logic [XW-1:0]     x_left;
    logic [XW:0]       x_up;
    logic [ADDR_W-1:0] addr_next;
    logic [ROM_LAT:0]  blank_dly;

    // NOTE: every variable assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        addr_next = ADDR_W'(bus.DrawY >> SCALE_SH) * ADDR_W'(WORLD_W)
                  + ADDR_W'(bus.DrawX >> SCALE_SH) + ADDR_W'(x_off);
        x_up      = {1'b0, x_off} + (XW+1)'(STEP);
        x_right   = (x_up >= (XW+1)'(MAP_W)) ? XW'(MAP_W) : x_up[XW-1:0];
        x_left    = (x_off <= XW'(STEP)) ? '0 : x_off - XW'(STEP);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge, independent of statement order.
    // NOTE: the blank delay line is a handful of flops, not a RAM, so it is
    // cleared on reset to keep idx_valid low until real pixels arrive.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.rom_addr  <= '0;
            blank_dly     <= '0;
            bus.idx_out   <= 5'(BG_IDX);
            bus.idx_valid <= 1'b0;
        end else begin
            bus.rom_addr  <= addr_next;
            blank_dly     <= {blank_dly[ROM_LAT-1:0], bus.blank_n};
            bus.idx_out   <= blank_dly[ROM_LAT] ? bus.rom_q : 5'(BG_IDX);
            bus.idx_valid <= blank_dly[ROM_LAT];
        end
    end

    // Offset only moves on frame_start, so a visible frame always uses one x_off.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            x_off          <= '0;
            bus.room_ack   <= 1'b0;
            bus.sliding    <= 1'b0;
            bus.slide_done <= 1'b0;
        end else begin
            bus.room_ack   <= 1'b0;
            bus.slide_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.room_req && bus.room_dir && x_off == '0) begin
                        bus.room_ack <= 1'b1;
                        bus.sliding  <= 1'b1;
                        state        <= SLIDE_R;
                    end else if (bus.room_req && !bus.room_dir && x_off == XW'(MAP_W)) begin
                        bus.room_ack <= 1'b1;
                        bus.sliding  <= 1'b1;
                        state        <= SLIDE_L;
                    end
                end
                SLIDE_R: begin
                    if (bus.frame_start) begin
                        x_off <= x_right;
                        if (x_right == XW'(MAP_W)) begin
                            bus.sliding    <= 1'b0;
                            bus.slide_done <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                SLIDE_L: begin
                    if (bus.frame_start) begin
                        x_off <= x_left;
                        if (x_left == '0) begin
                            bus.sliding    <= 1'b0;
                            bus.slide_done <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
